// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory side of the core: the VRAM window
// geometry, the fill-engine state type and two small helpers.
//   VRAM_WORDS : number of tile cells in the VRAM window
//   IDX_W      : width of a VRAM word index or run length
//   VRAM_BASE  : byte-address base of the window (bit 14 selects VRAM)
package dmem_pkg;

  localparam int          VRAM_WORDS = 2400;
  localparam int          IDX_W      = 12;
  localparam logic [31:0] VRAM_BASE  = 32'h0000_4000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  // A run [start, start+len) is legal when its end does not pass the window.
  // The sum is taken one bit wider so it cannot wrap.
  function automatic logic range_ok(input logic [IDX_W-1:0] start_idx,
                                    input logic [IDX_W-1:0] len);
    logic [IDX_W:0] sum;
    sum = {1'b0, start_idx} + {1'b0, len};
    return (sum <= (IDX_W+1)'(VRAM_WORDS));
  endfunction

  // Map a VRAM word index onto the dmem address bus.
  function automatic logic [31:0] vram_addr(input logic [IDX_W-1:0] idx);
    return VRAM_BASE | {{(32-IDX_W){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/dmem_port_mux.sv
// 2:1 select of the dmem write port between the CPU and the fill engine.
// Purely combinational so the CPU path has zero added latency, including
// while the engine is held in reset.
//   fill_gnt            : engine owns the port this cycle
//   cpu_we/cpu_a/cpu_wd : CPU side of the port
//   fill_a/fill_wd      : engine side (engine always writes when granted)
//   mem_we/mem_a/mem_wd : to dmem
module dmem_port_mux (
  input  logic        fill_gnt,
  input  logic        cpu_we,
  input  logic [31:0] cpu_a,
  input  logic [31:0] cpu_wd,
  input  logic [31:0] fill_a,
  input  logic [31:0] fill_wd,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd
);

  assign mem_we = fill_gnt ? 1'b1    : cpu_we;
  assign mem_a  = fill_gnt ? fill_a  : cpu_a;
  assign mem_wd = fill_gnt ? fill_wd : cpu_wd;

endmodule

// File: rtl/vram_fill_ctrl.sv
// VRAM fill/clear engine. Writes one constant word into a contiguous run of
// VRAM tile words, using only cycles in which the CPU makes no data access.
//   clk, reset          : clock, asynchronous active-high reset
//   cpu_req/we/a/wd     : CPU data port (req = read or write this cycle)
//   start, abort        : launch (sampled only in IDLE) / cancel an active fill
//   start_idx, len      : first word index and number of words
//   fill_val            : word written to every cell
//   mem_we/a/wd         : to dmem
//   busy, done, err     : FILL state, completion pulse, range-reject pulse
//   state_dbg           : current FSM state, for observation only
//
// Handshake: start is a single-cycle request taken only in IDLE; parameters
// are captured on that edge and later input changes are ignored. The engine
// then writes one word per cycle in which cpu_req is low; a CPU access simply
// stalls it. done pulses one cycle after the last write; err pulses one cycle
// after a start whose run would pass the end of VRAM. abort wins over
// completion, so an abort on the final write suppresses done.
module vram_fill_ctrl
  import dmem_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_a,
  input  logic [31:0]      cpu_wd,
  input  logic             start,
  input  logic             abort,
  input  logic [IDX_W-1:0] start_idx,
  input  logic [IDX_W-1:0] len,
  input  logic [31:0]      fill_val,
  output logic             mem_we,
  output logic [31:0]      mem_a,
  output logic [31:0]      mem_wd,
  output logic             busy,
  output logic             done,
  output logic             err,
  output fill_state_t      state_dbg
);

  fill_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] remain_q, remain_d;
  logic [31:0]      value_q, value_d;
  logic             err_q, err_d;
  logic             fill_gnt;

  assign fill_gnt = (state_q == FILL) && !cpu_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      remain_q <= '0;
      value_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      remain_q <= remain_d;
      value_q  <= value_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    remain_d = remain_q;
    value_d  = value_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Out-of-range is rejected before the zero-length shortcut.
          if (!range_ok(start_idx, len)) begin
            err_d = 1'b1;
          end else if (len == '0) begin
            state_d = DONE;
          end else begin
            state_d  = FILL;
            idx_d    = start_idx;
            remain_d = len;
            value_d  = fill_val;
          end
        end
      end
      FILL: begin
        if (fill_gnt) begin
          idx_d    = idx_q + IDX_W'(1);
          remain_d = remain_q - IDX_W'(1);
        end
        if (abort) begin
          state_d = IDLE;
        end else if (fill_gnt && (remain_q == IDX_W'(1))) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == FILL);
  assign done      = (state_q == DONE);
  assign err       = err_q;
  assign state_dbg = state_q;

  dmem_port_mux u_mux (
    .fill_gnt (fill_gnt),
    .cpu_we   (cpu_we),
    .cpu_a    (cpu_a),
    .cpu_wd   (cpu_wd),
    .fill_a   (vram_addr(idx_q)),
    .fill_wd  (value_q),
    .mem_we   (mem_we),
    .mem_a    (mem_a),
    .mem_wd   (mem_wd)
  );

endmodule
